// File: rtl/fsab_mem_rdret_pkg.sv
// rtl/fsab_mem_rdret_pkg.sv - shared FSAB widths and read-return serializer states
package fsab_mem_rdret_pkg;

    // Mirrors of the shared FSAB / memory defines.
    localparam int FSAB_DATA_W          = 64;
    localparam int FSAB_DID_W           = 4;
    localparam int FSAB_LEN_W           = 4;
    localparam int FSAB_LEN_MAX         = 8;
    localparam int FSAB_INITIAL_CREDITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } rdret_state_e;

endpackage

// File: rtl/fsab_sync_fifo.sv
// rtl/fsab_sync_fifo.sv - synchronous FIFO, RAM storage read through the registered read pointer
module fsab_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             Nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written, so full does not block.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!Nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsab_mem_rdret.sv
// rtl/fsab_mem_rdret.sv - MIG read-return capture and FSAB inbound word serializer
module fsab_mem_rdret
    import fsab_mem_rdret_pkg::*;
#(
    parameter int DATA_W     = FSAB_DATA_W,
    parameter int DID_W      = FSAB_DID_W,
    parameter int LEN_W      = FSAB_LEN_W,
    parameter int LEN_MAX    = FSAB_LEN_MAX,
    parameter int TAG_DEPTH  = FSAB_INITIAL_CREDITS,
    parameter int BEAT_DEPTH = 16
) (
    input  logic                clk,
    input  logic                Nrst,
    input  logic                req_valid,
    input  logic [DID_W-1:0]    req_did,
    input  logic [DID_W-1:0]    req_subdid,
    input  logic [LEN_W-1:0]    req_len,
    output logic                req_ready,
    input  logic                rd_data_valid,
    input  logic [2*DATA_W-1:0] rd_data,
    output logic                fsabi_valid,
    output logic [DID_W-1:0]    fsabi_did,
    output logic [DID_W-1:0]    fsabi_subdid,
    output logic [DATA_W-1:0]   fsabi_data,
    output logic                err_overflow
);

    localparam int RW    = $clog2(BEAT_DEPTH + 1);
    localparam int TAG_W = 2 * DID_W + LEN_W;
    localparam logic [RW:0] RESV_HEAD = (RW+1)'(LEN_MAX / 2);
    localparam logic [RW:0] RESV_LIM  = (RW+1)'(BEAT_DEPTH);

    logic                tag_push, tag_pop, tag_full, tag_empty;
    logic [TAG_W-1:0]    tag_dout;
    logic                beat_push, beat_pop, beat_full, beat_empty;
    logic [2*DATA_W-1:0] beat_dout;

    logic [RW-1:0]       resv;
    logic [LEN_W:0]      len_inc;
    logic [RW-1:0]       resv_add;
    logic                resv_sub;
    logic                req_err, beat_unexp, beat_err;

    logic [DID_W-1:0]    t_did, t_subdid;
    logic [LEN_W-1:0]    t_len;
    logic [DID_W-1:0]    cur_did, cur_subdid;
    logic [LEN_W-1:0]    rem;

    rdret_state_e        state_q, state_d;
    logic                load, emit, emit_hi;

    // The MIG read FIFO cannot be stalled, so every issued read must already own beat space.
    assign req_ready  = !tag_full && (({1'b0, resv} + RESV_HEAD) <= RESV_LIM);
    assign tag_push   = req_valid && req_ready;
    assign req_err    = req_valid && !req_ready;

    assign beat_unexp = tag_empty && !tag_push && (resv == '0);
    assign beat_push  = rd_data_valid && !beat_unexp && (!beat_full || beat_pop);
    assign beat_err   = rd_data_valid && !beat_push;

    assign len_inc    = {1'b0, req_len} + (LEN_W+1)'(1);
    assign resv_add   = tag_push ? RW'(len_inc[LEN_W:1]) : '0;
    assign resv_sub   = beat_pop && (resv != '0);

    assign t_did      = tag_dout[TAG_W-1 -: DID_W];
    assign t_subdid   = tag_dout[LEN_W +: DID_W];
    assign t_len      = tag_dout[LEN_W-1:0];

    fsab_sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .Nrst  (Nrst),
        .push  (tag_push),
        .din   ({req_did, req_subdid, req_len}),
        .pop   (tag_pop),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty)
    );

    fsab_sync_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (BEAT_DEPTH)
    ) u_beat_fifo (
        .clk   (clk),
        .Nrst  (Nrst),
        .push  (beat_push),
        .din   (rd_data),
        .pop   (beat_pop),
        .dout  (beat_dout),
        .full  (beat_full),
        .empty (beat_empty)
    );

    always_ff @(posedge clk) begin
        if (!Nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tag_pop  = 1'b0;
        beat_pop = 1'b0;
        load     = 1'b0;
        emit     = 1'b0;
        emit_hi  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!tag_empty) begin
                    if (t_len == '0) begin
                        tag_pop = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (!beat_empty) begin
                    emit = 1'b1;
                    // Odd length: the upper word of the final beat is dropped here.
                    if (rem == LEN_W'(1)) begin
                        beat_pop = 1'b1;
                        tag_pop  = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_HI;
                    end
                end
            end
            ST_HI: begin
                emit     = 1'b1;
                emit_hi  = 1'b1;
                beat_pop = 1'b1;
                if (rem == LEN_W'(1)) begin
                    tag_pop = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Nrst) begin
            resv         <= '0;
            cur_did      <= '0;
            cur_subdid   <= '0;
            rem          <= '0;
            fsabi_valid  <= 1'b0;
            fsabi_did    <= '0;
            fsabi_subdid <= '0;
            fsabi_data   <= '0;
            err_overflow <= 1'b0;
        end else begin
            resv <= resv + resv_add - RW'(resv_sub);
            if (load) begin
                cur_did    <= t_did;
                cur_subdid <= t_subdid;
                rem        <= t_len;
            end else if (emit) begin
                rem <= rem - LEN_W'(1);
            end
            fsabi_valid <= emit;
            if (emit) begin
                fsabi_did    <= cur_did;
                fsabi_subdid <= cur_subdid;
                fsabi_data   <= emit_hi ? beat_dout[2*DATA_W-1:DATA_W] : beat_dout[DATA_W-1:0];
            end
            if (req_err || beat_err) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule
